// File: rtl/io_uart_if.sv
// ----------------------------------------------------------------------------
// io_uart_if: core IO-bus bundle (address, data, write strobe, read data, irq).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface io_uart_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] io_addr_i;
  logic [7:0]        io_data_i;
  logic              io_we_i;
  logic [7:0]        io_data_o;
  logic              irq_o;

  modport master (
    output io_addr_i, io_data_i, io_we_i,
    input  io_data_o, irq_o
  );

  modport slave (
    input  io_addr_i, io_data_i, io_we_i,
    output io_data_o, irq_o
  );
endinterface

`default_nettype wire

// File: rtl/io_uart.sv
// ----------------------------------------------------------------------------
// io_uart: memory-mapped 8N1 UART with TX FIFO, RX holding register and irq.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module io_uart #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [15:0]       DIV_RESET  = 16'd433
) (
  input  logic       clk_i,
  input  logic       rst_i,
  io_uart_if.slave   io,
  input  logic       rx_i,
  output logic       tx_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // register file
  logic [1:0]  ctrl;
  logic [15:0] div;
  logic [7:0]  rx_hold;
  logic        rx_valid, rx_ovr, frame_err, tx_ovf;

  // address decode
  logic [ADDR_W-1:0] offset;
  logic in_win, wr_data, wr_stat, wr_ctrl, wr_dlo, wr_dhi;

  assign offset  = io.io_addr_i - BASE_ADDR;
  assign in_win  = (offset <= ADDR_W'(4));
  assign wr_data = io.io_we_i && in_win && (offset == ADDR_W'(0));
  assign wr_stat = io.io_we_i && in_win && (offset == ADDR_W'(1));
  assign wr_ctrl = io.io_we_i && in_win && (offset == ADDR_W'(2));
  assign wr_dlo  = io.io_we_i && in_win && (offset == ADDR_W'(3));
  assign wr_dhi  = io.io_we_i && in_win && (offset == ADDR_W'(4));

  // TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_full, push_ok, ovf_set, tx_pop, tx_empty;

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign push_ok   = wr_data && (!fifo_full || tx_pop);
  assign ovf_set   = wr_data && fifo_full && !tx_pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= io.io_data_i;
  end

  // TX FSM
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line_n, tx_bit_end;

  assign tx_bit_end = (tx_cnt == tx_div);
  assign tx_empty   = (fifo_cnt == '0) && (tx_state == ST_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (fifo_cnt != '0) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr];
          tx_div_n   = div;
          tx_cnt_n   = '0;
          tx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = ST_DATA;
        end else tx_cnt_n = tx_cnt + 16'd1;
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = ST_STOP;
        end else tx_cnt_n = tx_cnt + 16'd1;
      end
      ST_STOP: begin
        if (tx_bit_end) tx_state_n = ST_IDLE;
        else            tx_cnt_n   = tx_cnt + 16'd1;
      end
      default: tx_state_n = ST_IDLE;
    endcase
    // line level follows the next state so tx_o is a clean flop output
    tx_line_n = 1'b1;
    if (tx_state_n == ST_START)     tx_line_n = 1'b0;
    else if (tx_state_n == ST_DATA) tx_line_n = tx_shift_n[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_o     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_o     <= tx_line_n;
    end
  end

  // RX synchroniser plus one extra stage for falling-edge detection
  logic rx_s1, rx_s2, rx_s3, rx_fall;
  assign rx_fall = rx_s3 && !rx_s2;

  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [16:0] rx_half;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_load, rx_ferr, rx_half_hit, rx_bit_end;

  assign rx_half     = ({1'b0, rx_div} + 17'd1) >> 1;
  assign rx_half_hit = (({1'b0, rx_cnt} + 17'd1) >= rx_half);
  assign rx_bit_end  = (rx_cnt == rx_div);

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_div_n   = div;
          rx_cnt_n   = '0;
          rx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (rx_half_hit) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
        end else rx_cnt_n = rx_cnt + 16'd1;
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = ST_STOP;
        end else rx_cnt_n = rx_cnt + 16'd1;
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_load    = rx_s2;
          rx_ferr    = !rx_s2;
          rx_state_n = ST_IDLE;
        end else rx_cnt_n = rx_cnt + 16'd1;
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // registers, FIFO pointers, sticky flags (set beats write-1-to-clear)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl      <= '0;
      div       <= DIV_RESET;
      rx_hold   <= '0;
      rx_valid  <= 1'b0;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      io.irq_o  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl      <= io.io_data_i[1:0];
      if (wr_dlo)  div[7:0]  <= io.io_data_i;
      if (wr_dhi)  div[15:8] <= io.io_data_i;
      if (rx_load) rx_hold   <= rx_shift;
      rx_valid  <= rx_load | (rx_valid & !(wr_stat && io.io_data_i[0]));
      rx_ovr    <= (rx_load & rx_valid) | (rx_ovr & !(wr_stat && io.io_data_i[4]));
      frame_err <= rx_ferr | (frame_err & !(wr_stat && io.io_data_i[5]));
      tx_ovf    <= ovf_set | (tx_ovf & !(wr_stat && io.io_data_i[3]));
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      io.irq_o <= (ctrl[0] & rx_valid) | (ctrl[1] & tx_empty);
    end
  end

  always_comb begin
    io.io_data_o = 8'h00;
    if (in_win) begin
      case (offset)
        ADDR_W'(0): io.io_data_o = rx_hold;
        ADDR_W'(1): io.io_data_o = {2'b00, frame_err, rx_ovr, tx_ovf, tx_empty, fifo_full, rx_valid};
        ADDR_W'(2): io.io_data_o = {6'b0, ctrl};
        ADDR_W'(3): io.io_data_o = div[7:0];
        ADDR_W'(4): io.io_data_o = div[15:8];
        default:    io.io_data_o = 8'h00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_uart.sv
// ----------------------------------------------------------------------------
// tb_io_uart: directed + randomized checks of io_uart against a frame-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_io_uart;

  localparam logic [7:0] A_DATA = 8'h00, A_STAT = 8'h01, A_CTRL = 8'h02,
                         A_DLO  = 8'h03, A_DHI  = 8'h04;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   checks = 0, passed = 0, failed = 0;

  io_uart_if #(.ADDR_W(8)) bus ();

  io_uart #(.ADDR_W(8), .BASE_ADDR(8'h00), .FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus.slave),
    .rx_i  (rx),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected STATUS byte built from the model's view of each flag
  function automatic logic [7:0] status(input bit rxv, input bit full, input bit txe,
                                        input bit tovf, input bit ovr, input bit ferr);
    return {2'b00, ferr, ovr, tovf, txe, full, rxv};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_addr_i = a; bus.io_data_i = d; bus.io_we_i = 1'b1;
    @(negedge clk);
    bus.io_we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.io_addr_i = a;
    #1 d = bus.io_data_o;
  endtask

  task automatic set_div(input logic [15:0] d);
    wr(A_DLO, d[7:0]);
    wr(A_DHI, d[15:8]);
  endtask

  // waits for a start bit then samples every cycle of all 10 bit slots
  task automatic tx_capture(input int d, output logic [9:0] bits, output bit stable, output bit got);
    got = 1'b0; stable = 1'b1; bits = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin got = 1'b1; break; end
    end
    if (got) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c <= d; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (c == 0) bits[k] = tx;
          else if (tx !== bits[k]) stable = 1'b0;
        end
      end
    end
  endtask

  task automatic expect_frame(input string tag, input int d, input logic [7:0] b);
    logic [9:0] bits; bit stable, got;
    tx_capture(d, bits, stable, got);
    check({tag, "_start_seen"}, 32'(got), 32'd1);
    check({tag, "_bits"}, 32'(bits), 32'({1'b1, b, 1'b0}));
    check({tag, "_bit_width"}, 32'(stable), 32'd1);
  endtask

  task automatic send_rx(input int d, input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rx = f[k];
      repeat (d) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v, b;
    logic [7:0] burst [10];
    logic [9:0] cap_bits [9];
    bit         cap_stable [9], cap_got [9];
    int         d, lows;
    bit         seen;
    logic       irq_at, irq_next;

    bus.io_addr_i = '0; bus.io_data_i = '0; bus.io_we_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(bus.irq_o), 32'd0);
    rd(A_STAT, v); check("rst_status", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));
    rd(A_CTRL, v); check("rst_ctrl", 32'(v), 32'h00);
    rd(A_DLO, v);  check("rst_div_lo", 32'(v), 32'hB1);
    rd(A_DHI, v);  check("rst_div_hi", 32'(v), 32'h01);

    // outside the window: reads 0, writes ignored
    rd(8'h05, v); check("oow_read", 32'(v), 32'h00);
    wr(8'h05, 8'hFF); wr(8'hFF, 8'hFF);
    rd(A_CTRL, v); check("oow_ctrl", 32'(v), 32'h00);
    rd(A_DLO, v);  check("oow_div_lo", 32'(v), 32'hB1);

    // ctrl readback and tx-empty interrupt
    wr(A_CTRL, 8'hFE);
    rd(A_CTRL, v); check("ctrl_rb", 32'(v), 32'h02);
    #1 check("irq_txe", 32'(bus.irq_o), 32'd1);
    wr(A_CTRL, 8'h00);
    @(negedge clk); check("irq_txe_off", 32'(bus.irq_o), 32'd0);

    // directed TX frame
    set_div(16'd3);
    rd(A_DHI, v); check("div_hi_rb", 32'(v), 32'h00);
    wr(A_DATA, 8'hA5);
    expect_frame("tx_a5", 3, 8'hA5);
    rd(A_STAT, v); check("tx_a5_empty", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));

    // randomized TX frames at random divisors
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(1, 6);
      b = 8'($urandom);
      set_div(16'(d));
      wr(A_DATA, b);
      expect_frame("tx_rand", d, b);
    end
    rd(A_STAT, v); check("tx_rand_empty", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));

    // FIFO burst: 9 accepted, 10th overflows and is dropped
    set_div(16'd3);
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          bus.io_addr_i = A_DATA; bus.io_data_i = burst[i]; bus.io_we_i = 1'b1;
          @(negedge clk);
        end
        bus.io_we_i = 1'b0;
        bus.io_addr_i = A_STAT;
        #1 check("burst_full_no_ovf", 32'(bus.io_data_o), 32'(status(0, 1, 0, 0, 0, 0)));
        wr(A_DATA, burst[9]);
        bus.io_addr_i = A_STAT;
        #1 check("burst_ovf", 32'(bus.io_data_o), 32'(status(0, 1, 0, 1, 0, 0)));
      end
      begin
        for (int i = 0; i < 9; i++) tx_capture(3, cap_bits[i], cap_stable[i], cap_got[i]);
      end
    join
    for (int i = 0; i < 9; i++) begin
      check("burst_got", 32'(cap_got[i]), 32'd1);
      check("burst_bits", 32'(cap_bits[i]), 32'({1'b1, burst[i], 1'b0}));
      check("burst_width", 32'(cap_stable[i]), 32'd1);
    end
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("burst_no_10th", 32'(lows), 32'd0);
    wr(A_STAT, 8'h08);
    rd(A_STAT, v); check("tx_ovf_clr", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));

    // RX frame with irq latency
    wr(A_CTRL, 8'h01);
    seen = 1'b0; irq_at = 1'bx; irq_next = 1'bx;
    fork
      send_rx(3, 8'h3C, 1'b1);
      begin
        bus.io_addr_i = A_STAT;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          #1;
          if (bus.io_data_o[0] === 1'b1) begin
            seen = 1'b1;
            irq_at = bus.irq_o;
            @(negedge clk);
            #1 irq_next = bus.irq_o;
            break;
          end
        end
      end
    join
    check("rx_seen", 32'(seen), 32'd1);
    check("rx_irq_same", 32'(irq_at), 32'd0);
    check("rx_irq_next", 32'(irq_next), 32'd1);
    rd(A_DATA, v); check("rx_3c", 32'(v), 32'h3C);
    rd(A_STAT, v); check("rx_3c_stat", 32'(v), 32'(status(1, 0, 1, 0, 0, 0)));
    send_rx(3, 8'h81, 1'b1);
    rd(A_DATA, v); check("rx_81", 32'(v), 32'h81);
    rd(A_STAT, v); check("rx_ovr_stat", 32'(v), 32'(status(1, 0, 1, 0, 1, 0)));
    wr(A_STAT, 8'h11);
    rd(A_STAT, v); check("rx_clr", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));
    #1 check("rx_irq_clr", 32'(bus.irq_o), 32'd0);
    wr(A_CTRL, 8'h00);

    // randomized RX frames
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(3, 7);
      b = 8'($urandom);
      set_div(16'(d));
      send_rx(d, b, 1'b1);
      rd(A_DATA, v); check("rx_rand", 32'(v), 32'(b));
      rd(A_STAT, v); check("rx_rand_stat", 32'(v), 32'(status(1, 0, 1, 0, 0, 0)));
      wr(A_STAT, 8'h01);
    end

    // glitch reject and framing error
    set_div(16'd3);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (50) @(negedge clk);
    rd(A_STAT, v); check("glitch_stat", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));
    send_rx(3, 8'($urandom), 1'b0);
    rd(A_STAT, v); check("ferr_stat", 32'(v), 32'(status(0, 0, 1, 0, 0, 1)));
    wr(A_STAT, 8'h20);
    rd(A_STAT, v); check("ferr_clr", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));

    // reset in the middle of data bit 3
    b = 8'($urandom);
    wr(A_DATA, b);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (tx === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_rst_start", 32'(seen), 32'd1);
    wr(A_DATA, 8'($urandom));
    wr(A_DATA, 8'($urandom));
    repeat (13) @(negedge clk);
    check("mid_rst_bit3", 32'(tx), 32'(b[3]));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    rd(A_STAT, v); check("mid_rst_stat", 32'(v), 32'(status(0, 0, 1, 0, 0, 0)));
    rd(A_DLO, v);  check("mid_rst_div", 32'(v), 32'hB1);
    lows = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("mid_rst_quiet", 32'(lows), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
